// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory arbiter slice.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int DEF_NCORES = 4;
  localparam int DEF_AW     = 8;
  localparam int DEF_DW     = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request bus plus RAM-side strobe bus of the memory arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NCORES = DEF_NCORES,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW
);

  logic [NCORES-1:0]    req;
  logic [NCORES-1:0]    we;
  logic [NCORES*AW-1:0] addr;
  logic [NCORES*DW-1:0] wdata;
  logic [NCORES-1:0]    done;
  logic [DW-1:0]        rdata;
  logic                 busy;
  logic                 mem_en;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic [DW-1:0]        mem_rdata;

  // The arbiter sits between the cores and the RAM.
  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  // The cores and the RAM together, as seen from outside the arbiter.
  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_picker.sv
// Combinational one-hot selector: first set request searching upward from last_grant+1.
module mem_arb_picker #(
  parameter int NCORES = 4,
  parameter int IW     = 2
) (
  input  logic [NCORES-1:0] reqm,
  input  logic [IW-1:0]     last_grant,
  output logic [NCORES-1:0] grant_oh,
  output logic [IW-1:0]     grant_idx,
  output logic              any
);

  // Tying last_grant to NCORES-1 turns this search into fixed lowest-index priority.
  always_comb begin
    logic [IW-1:0] idx;
    idx       = '0;
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int off = 1; off <= NCORES; off++) begin
      idx = IW'((int'(last_grant) + off) % NCORES);
      if (!any && reqm[idx]) begin
        any           = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-state arbiter sharing one single-port RAM among NCORES cores, fixed 3-cycle turnaround.
// Define MEMARB_ROUND_ROBIN_EN for round-robin selection; otherwise the lowest index wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NCORES = DEF_NCORES,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW
) (
  input logic          clk,
  input logic          resetn,
  mem_arbiter_if.slave bus
);

  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  state_t            state;
  logic [NCORES-1:0] cur_oh;
  logic [NCORES-1:0] reqm;
  logic [NCORES-1:0] pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [IW-1:0]     search_base;

  // A core whose done is showing must not win again at the same edge.
  assign reqm = bus.req & ~bus.done;

`ifdef MEMARB_ROUND_ROBIN_EN
  logic [IW-1:0] last_grant;

  assign search_base = last_grant;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= IW'(NCORES - 1);
    end else if (state == IDLE && pick_any) begin
      last_grant <= pick_idx;
    end
  end
`else
  assign search_base = IW'(NCORES - 1);
`endif

  mem_arb_picker #(
    .NCORES (NCORES),
    .IW     (IW)
  ) u_picker (
    .reqm       (reqm),
    .last_grant (search_base),
    .grant_oh   (pick_oh),
    .grant_idx  (pick_idx),
    .any        (pick_any)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cur_oh        <= '0;
      bus.done      <= '0;
      bus.rdata     <= '0;
      bus.busy      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.done   <= '0;
      bus.mem_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            cur_oh        <= pick_oh;
            bus.mem_we    <= bus.we[pick_idx];
            bus.mem_addr  <= bus.addr[pick_idx*AW +: AW];
            bus.mem_wdata <= bus.wdata[pick_idx*DW +: DW];
            bus.mem_en    <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          state <= RESP;
        end
        RESP: begin
          // mem_we still holds the latched direction of this transaction.
          if (!bus.mem_we) begin
            bus.rdata <= bus.mem_rdata;
          end
          bus.done <= cur_oh;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
